// File: rtl/mips_multi_cycle.sv
// Multi-cycle MIPS subset core sharing one memory port for fetch, load and store.
// Stops in HALT on any illegal opcode or funct until reset.
module mips_multi_cycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ready,
    output logic [31:0]      pc,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    input  logic [4:0]       dbg_addr,
    output logic [31:0]      dbg_data
);

    localparam int unsigned RegAw = $clog2(NUM_REGS);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] FnAdd   = 6'h20;
    localparam logic [5:0] FnSub   = 6'h22;
    localparam logic [5:0] FnAnd   = 6'h24;
    localparam logic [5:0] FnOr    = 6'h25;
    localparam logic [5:0] FnSlt   = 6'h2A;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      imm_q, imm_d;
    logic [31:0]      alu_q, alu_d;
    logic [31:0]      mdr_q, mdr_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [31:0]      regs_q [NUM_REGS];

    logic             rf_we;
    logic [RegAw-1:0] rf_waddr;
    logic [31:0]      rf_wdata;

    logic [5:0]       opcode, funct;
    logic [RegAw-1:0] rs, rt, rd, dbg_idx;
    logic [31:0]      rs_val, rt_val, alu_r;
    logic             op_legal;

    assign opcode  = ir_q[31:26];
    assign funct   = ir_q[5:0];
    assign rs      = ir_q[21 +: RegAw];
    assign rt      = ir_q[16 +: RegAw];
    assign rd      = ir_q[11 +: RegAw];
    assign dbg_idx = dbg_addr[RegAw-1:0];

    assign rs_val   = (rs == '0) ? 32'h0 : regs_q[rs];
    assign rt_val   = (rt == '0) ? 32'h0 : regs_q[rt];
    assign dbg_data = (dbg_idx == '0) ? 32'h0 : regs_q[dbg_idx];

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OpRtype: op_legal = funct inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt};
            OpJ, OpBeq, OpAddi, OpLw, OpSw: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_r = 32'h0;
        case (funct)
            FnAdd:   alu_r = a_q + b_q;
            FnSub:   alu_r = a_q - b_q;
            FnAnd:   alu_r = a_q & b_q;
            FnOr:    alu_r = a_q | b_q;
            FnSlt:   alu_r = ($signed(a_q) < $signed(b_q)) ? 32'h1 : 32'h0;
            default: alu_r = 32'h0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        instret_d = instret_q;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = 32'h0;
        case (state_q)
            StFetch: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                a_d     = rs_val;
                b_d     = rt_val;
                imm_d   = {{16{ir_q[15]}}, ir_q[15:0]};
                state_d = op_legal ? StExec : StHalt;
            end
            StExec: begin
                case (opcode)
                    OpRtype: begin
                        alu_d   = alu_r;
                        state_d = StWb;
                    end
                    OpAddi: begin
                        alu_d   = a_q + imm_q;
                        state_d = StWb;
                    end
                    OpLw, OpSw: begin
                        alu_d   = a_q + imm_q;
                        state_d = StMem;
                    end
                    OpBeq: begin
                        // pc_q already points past the branch
                        if (a_q == b_q) pc_d = pc_q + {imm_q[29:0], 2'b00};
                        instret_d = instret_q + CNT_W'(1);
                        state_d   = StFetch;
                    end
                    default: begin
                        pc_d      = {pc_q[31:28], ir_q[25:0], 2'b00};
                        instret_d = instret_q + CNT_W'(1);
                        state_d   = StFetch;
                    end
                endcase
            end
            StMem: begin
                if (mem_ready) begin
                    if (opcode == OpSw) begin
                        instret_d = instret_q + CNT_W'(1);
                        state_d   = StFetch;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                if (opcode == OpLw) begin
                    rf_waddr = rt;
                    rf_wdata = mdr_q;
                end else if (opcode == OpAddi) begin
                    rf_waddr = rt;
                    rf_wdata = alu_q;
                end else begin
                    rf_waddr = rd;
                    rf_wdata = alu_q;
                end
                rf_we     = (rf_waddr != '0);
                instret_d = instret_q + CNT_W'(1);
                state_d   = StFetch;
            end
            default: state_d = StHalt;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0;
            a_q       <= 32'h0;
            b_q       <= 32'h0;
            imm_q     <= 32'h0;
            alu_q     <= 32'h0;
            mdr_q     <= 32'h0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            instret_q <= instret_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 32'h0;
        end else if (rf_we) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    // Reset gates the request so the first fetch starts the cycle after release
    assign mem_req   = !reset && (state_q == StFetch || state_q == StMem);
    assign mem_we    = mem_req && (state_q == StMem) && (opcode == OpSw);
    assign mem_addr  = {((state_q == StMem) ? alu_q[31:2] : pc_q[31:2]), 2'b00};
    assign mem_wdata = b_q;
    assign pc        = pc_q;
    assign state     = state_q;
    assign instret   = instret_q;
    assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_mips_multi_cycle.sv
// Directed bench for mips_multi_cycle: a program table with per-instruction latency,
// cycle, PC and register expectations, plus reset, branch-loop and halt sequences.
module tb_mips_multi_cycle;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, mem_ready, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, dbg_data, instret;
    logic [2:0]  state;
    logic [4:0]  dbg_addr;

    int          lat;
    bit          stray;
    int          wait_cnt;
    logic [31:0] prog   [128];
    logic [31:0] dmem   [128];
    bit          wvalid [128];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] instr;
        int          lat;
        int          rix;
        logic [31:0] rval;
        logic [31:0] exp_pc;
        int          exp_cyc;
        bit          mon;
        logic        m_we;
        logic [31:0] m_addr;
        logic [31:0] m_data;
    } vec_t;

    vec_t vecs [18];

    always #5 clk = ~clk;

    mips_multi_cycle dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc        (pc),
        .state     (state),
        .instret   (instret),
        .halted    (halted),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    // Memory: instruction image plus a store overlay, ready after lat wait cycles
    assign mem_ready = stray || (mem_req && wait_cnt >= lat);
    assign mem_rdata = wvalid[mem_addr[8:2]] ? dmem[mem_addr[8:2]] : prog[mem_addr[8:2]];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 0;
            for (int i = 0; i < 128; i++) wvalid[i] <= 1'b0;
        end else begin
            if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
            else wait_cnt <= 0;
            if (mem_req && mem_ready && mem_we) begin
                dmem[mem_addr[8:2]]   <= mem_wdata;
                wvalid[mem_addr[8:2]] <= 1'b1;
            end
        end
    end

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] tgt);
        return {6'h02, tgt};
    endfunction

    function automatic vec_t plain(input int l);
        vec_t v;
        v = '{32'h0, l, 0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 32'h0};
        return v;
    endfunction

    task automatic get_reg(input int r, output logic [31:0] v);
        dbg_addr = 5'(r);
        #1;
        v = dbg_data;
    endtask

    // Runs until instret reaches exp_ir; counts cycles and watches MEM-state outputs
    task automatic run_instr(input vec_t v, input int exp_ir, output int cyc);
        int mem_cyc = 0;
        lat = v.lat;
        cyc = 0;
        while (instret != 32'(exp_ir) && !halted && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (v.mon && state == 3'd3) begin
                mem_cyc++;
                check("mem_req_in_mem", {31'd0, mem_req}, 32'd1);
                check("mem_we_in_mem", {31'd0, mem_we}, {31'd0, v.m_we});
                check("mem_addr_in_mem", mem_addr, v.m_addr);
                if (v.m_we) check("mem_wdata_in_mem", mem_wdata, v.m_data);
            end
        end
        check("instret_retire", instret, 32'(exp_ir));
        if (v.mon) check("mem_cycles", 32'(mem_cyc), 32'(v.lat + 1));
    endtask

    task automatic wait_halt(input int bound);
        int c = 0;
        while (!halted && c < bound) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("halted", {31'd0, halted}, 32'd1);
    endtask

    initial begin
        logic [31:0] addr;
        logic [31:0] rv;
        int          cyc;
        vec_t        pv;

        reset    = 1'b1;
        lat      = 0;
        stray    = 1'b0;
        dbg_addr = 5'd0;
        for (int i = 0; i < 128; i++) prog[i] = 32'h0;

        vecs[0]  = '{enc_i(6'h08, 0, 1, 16'd5), 0, 1, 32'd5, 32'h04, 4, 0, 0, 0, 0};
        vecs[1]  = '{enc_i(6'h08, 0, 1, 16'hFFFD), 0, 1, 32'hFFFF_FFFD, 32'h08, 4, 0, 0, 0, 0};
        vecs[2]  = '{enc_i(6'h08, 0, 2, 16'd2), 1, 2, 32'd2, 32'h0C, 5, 0, 0, 0, 0};
        vecs[3]  = '{enc_r(1, 2, 3, 6'h2A), 0, 3, 32'd1, 32'h10, 4, 0, 0, 0, 0};
        vecs[4]  = '{enc_r(2, 1, 4, 6'h22), 0, 4, 32'd5, 32'h14, 4, 0, 0, 0, 0};
        vecs[5]  = '{enc_r(1, 2, 6, 6'h25), 2, 6, 32'hFFFF_FFFF, 32'h18, 6, 0, 0, 0, 0};
        vecs[6]  = '{enc_r(1, 4, 7, 6'h24), 0, 7, 32'd5, 32'h1C, 4, 0, 0, 0, 0};
        vecs[7]  = '{enc_r(1, 4, 8, 6'h20), 0, 8, 32'd2, 32'h20, 4, 0, 0, 0, 0};
        vecs[8]  = '{enc_r(2, 1, 3, 6'h2A), 0, 3, 32'd0, 32'h24, 4, 0, 0, 0, 0};
        vecs[9]  = '{enc_i(6'h08, 0, 10, 16'hFFFF), 0, 10, 32'hFFFF_FFFF, 32'h28, 4, 0, 0, 0, 0};
        vecs[10] = '{enc_r(10, 10, 11, 6'h20), 0, 11, 32'hFFFF_FFFE, 32'h2C, 4, 0, 0, 0, 0};
        vecs[11] = '{enc_i(6'h2B, 0, 1, 16'd8), 3, 1, 32'hFFFF_FFFD, 32'h30, 10,
                     1, 1, 32'h8, 32'hFFFF_FFFD};
        vecs[12] = '{enc_i(6'h23, 0, 5, 16'd8), 3, 5, 32'hFFFF_FFFD, 32'h34, 11,
                     1, 0, 32'h8, 32'h0};
        vecs[13] = '{enc_i(6'h08, 0, 0, 16'd7), 0, 0, 32'd0, 32'h38, 4, 0, 0, 0, 0};
        vecs[14] = '{enc_i(6'h04, 1, 2, 16'd5), 0, 4, 32'd5, 32'h3C, 3, 0, 0, 0, 0};
        vecs[15] = '{enc_i(6'h04, 4, 4, 16'd2), 0, 4, 32'd5, 32'h48, 3, 0, 0, 0, 0};
        vecs[16] = '{enc_j(26'h40), 0, 1, 32'hFFFF_FFFD, 32'h100, 3, 0, 0, 0, 0};
        vecs[17] = '{enc_i(6'h08, 11, 12, 16'h8000), 1, 12, 32'hFFFF_7FFE, 32'h104, 5,
                     0, 0, 0, 0};

        addr = 32'h0;
        for (int i = 0; i < 18; i++) begin
            prog[addr[8:2]] = vecs[i].instr;
            addr = vecs[i].exp_pc;
        end
        prog[addr[8:2]] = {6'h3F, 26'h0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_instret", instret, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        get_reg(1, rv);
        check("rst_r1", rv, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            run_instr(vecs[i], i + 1, cyc);
            check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
            check($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
            get_reg(vecs[i].rix, rv);
            check($sformatf("v%0d_r%0d", i, vecs[i].rix), rv, vecs[i].rval);
        end
        check("stored_word", dmem[2], 32'hFFFF_FFFD);

        // Illegal opcode 3F: terminal halt, stray ready ignored
        lat = 0;
        wait_halt(20);
        check("halt_state", {29'd0, state}, 32'd5);
        check("halt_pc", pc, 32'h108);
        check("halt_instret", instret, 32'd18);
        stray = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            check("halt_mem_req", {31'd0, mem_req}, 32'd0);
        end
        stray = 1'b0;
        check("halt_pc_frozen", pc, 32'h108);
        check("halt_state_held", {29'd0, state}, 32'd5);
        check("halt_instret_held", instret, 32'd18);

        // j to 0x10, then beq $0,$0,-1 loops at 0x10
        reset = 1'b1;
        #1;
        check("rst2_state", {29'd0, state}, 32'd0);
        check("rst2_halted", {31'd0, halted}, 32'd0);
        get_reg(1, rv);
        check("rst2_r1_cleared", rv, 32'h0);
        prog[0] = enc_j(26'h4);
        prog[4] = enc_i(6'h04, 0, 0, 16'hFFFF);
        @(posedge clk);
        #1;
        reset = 1'b0;
        pv = plain(0);
        for (int k = 1; k <= 3; k++) begin
            run_instr(pv, k, cyc);
            check($sformatf("loop%0d_cycles", k), 32'(cyc), 32'd3);
            check($sformatf("loop%0d_pc", k), pc, 32'h10);
        end

        // Reset in the middle of a slow lw
        reset = 1'b1;
        prog[0] = enc_i(6'h23, 0, 5, 16'h20);
        prog[8] = 32'hDEAD_BEEF;
        lat     = 5;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        while (state != 3'd3 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("lw_pending_state", {29'd0, state}, 32'd3);
        reset = 1'b1;
        #1;
        check("abort_pc", pc, 32'h0);
        check("abort_instret", instret, 32'd0);
        check("abort_state", {29'd0, state}, 32'd0);
        check("abort_mem_req", {31'd0, mem_req}, 32'd0);
        get_reg(5, rv);
        check("abort_r5", rv, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(plain(0), 1, cyc);
        check("lw_cycles", 32'(cyc), 32'd5);
        check("lw_pc", pc, 32'h4);
        get_reg(5, rv);
        check("lw_r5", rv, 32'hDEAD_BEEF);

        // Illegal funct 0x21 under opcode 0
        reset = 1'b1;
        prog[0] = enc_r(1, 2, 3, 6'h21);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_halt(20);
        check("badfn_state", {29'd0, state}, 32'd5);
        check("badfn_pc", pc, 32'h4);
        check("badfn_instret", instret, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
